// File: rtl/tcp_dma_pkg.sv
// tcp_dma_pkg
//   Shared definitions for the TCP RX -> DMA ring writer:
//   - state_t     : FSM state encoding of tcp_rx_to_dma_write
//   - DMA_ALIGN   : byte alignment of every packet slot in the host ring
//   - sat_inc32   : saturating 32-bit increment used for statistics counters
package tcp_dma_pkg;

    typedef enum logic [2:0] {
        UNCFG  = 3'd0,
        IDLE   = 3'd1,
        CMD    = 3'd2,
        STREAM = 3'd3,
        DROP   = 3'd4
    } state_t;

    localparam int unsigned DMA_ALIGN = 64;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ring_space_calc.sv
// ring_space_calc
//   Purely combinational ring-space evaluation for one packet.
//   Ports:
//     size   : ring size in bytes (power of two, >= 64)
//     wr_ptr : produced byte pointer (free-running, wraps mod 2^PTR_W)
//     rd_ptr : host-consumed byte pointer (free-running)
//     len    : packet length in bytes
//     alen   : len rounded up to DMA_ALIGN
//     pad    : bytes skipped so the packet does not straddle the ring end
//     free   : bytes available in the ring
//     fits   : free >= pad + alen
module ring_space_calc
    import tcp_dma_pkg::*;
#(
    parameter int PTR_W = 32
) (
    input  logic [PTR_W-1:0] size,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [PTR_W-1:0] rd_ptr,
    input  logic [15:0]      len,
    output logic [PTR_W-1:0] alen,
    output logic [PTR_W-1:0] pad,
    output logic [PTR_W-1:0] free,
    output logic             fits
);

    localparam logic [PTR_W-1:0] ALIGN_MASK = PTR_W'(DMA_ALIGN - 1);

    logic [PTR_W-1:0] off;
    logic [PTR_W-1:0] used;

    always_comb begin
        alen = (PTR_W'(len) + ALIGN_MASK) & ~ALIGN_MASK;
        off  = wr_ptr & (size - 1'b1);
        // A packet that would run past the end of the ring restarts at offset 0.
        pad  = ((off + alen) > size) ? (size - off) : '0;
        // Pointers are free-running, so the subtraction wraps naturally.
        used = wr_ptr - rd_ptr;
        free = size - used;
        fits = (free >= (pad + alen));
    end

endmodule

// File: rtl/tcp_rx_to_dma_write.sv
// tcp_rx_to_dma_write
//   Writes received TCP payload into a host ring buffer through a DMA
//   write command/data stream. Each packet gets one DMA command at a
//   64-byte-aligned ring offset; payload beats pass straight through.
//   Packets with len=0, len>ring size (or, with the filter, a foreign
//   session) are drained and counted in drop_cnt.
//   Optional build macro: TCP_RX_SESSION_FILTER_EN
//     defined   : s_cfg_data is 112 bits, session_id in [111:96]
//     undefined : s_cfg_data is 96 bits, every session accepted
//   Ports:
//     clk, rst                    : clock, synchronous active-high reset
//     s_cfg_*                     : {base_addr[95:32], ring_size[31:0]}
//     s_rd_ptr_valid, s_rd_ptr    : host-consumed byte pointer update
//     s_axis_rx_meta_*            : {len[31:16], session[15:0]}
//     s_axis_rx_data_*            : payload stream in
//     m_axis_dma_write_cmd_*      : DMA command (address, length)
//     m_axis_dma_write_data_*     : payload stream out
//     wr_ptr, drop_cnt            : produced byte pointer, dropped packets
module tcp_rx_to_dma_write
    import tcp_dma_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int PTR_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_cfg_valid,
    output logic                s_cfg_ready,
`ifdef TCP_RX_SESSION_FILTER_EN
    input  logic [111:0]        s_cfg_data,
`else
    input  logic [95:0]         s_cfg_data,
`endif
    input  logic                s_rd_ptr_valid,
    input  logic [PTR_W-1:0]    s_rd_ptr,
    input  logic                s_axis_rx_meta_valid,
    output logic                s_axis_rx_meta_ready,
    input  logic [31:0]         s_axis_rx_meta_data,
    input  logic                s_axis_rx_data_valid,
    output logic                s_axis_rx_data_ready,
    input  logic [DATA_W-1:0]   s_axis_rx_data_data,
    input  logic [DATA_W/8-1:0] s_axis_rx_data_keep,
    input  logic                s_axis_rx_data_last,
    output logic                m_axis_dma_write_cmd_valid,
    input  logic                m_axis_dma_write_cmd_ready,
    output logic [63:0]         m_axis_dma_write_cmd_address,
    output logic [31:0]         m_axis_dma_write_cmd_length,
    output logic                m_axis_dma_write_data_valid,
    input  logic                m_axis_dma_write_data_ready,
    output logic [DATA_W-1:0]   m_axis_dma_write_data_data,
    output logic [DATA_W/8-1:0] m_axis_dma_write_data_keep,
    output logic                m_axis_dma_write_data_last,
    output logic [PTR_W-1:0]    wr_ptr,
    output logic [31:0]         drop_cnt
);

    state_t           state_q;
    logic [63:0]      base_q;
    logic [31:0]      size_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [31:0]      drop_cnt_q;
    logic [15:0]      len_p0;
    logic [PTR_W-1:0] alen_p0;
`ifdef TCP_RX_SESSION_FILTER_EN
    logic [15:0]      session_id_q;
`endif

    logic [15:0]      meta_len;
    logic [15:0]      meta_session;
    logic [PTR_W-1:0] size_ptr;
    logic [PTR_W-1:0] calc_alen;
    logic [PTR_W-1:0] calc_pad;
    logic [PTR_W-1:0] calc_free;
    logic             calc_fits;
    logic             meta_drop;
    logic             cfg_hs;
    logic             meta_hs;

    assign meta_len     = s_axis_rx_meta_data[31:16];
    assign meta_session = s_axis_rx_meta_data[15:0];
    assign size_ptr     = PTR_W'(size_q);

    ring_space_calc #(
        .PTR_W (PTR_W)
    ) u_space (
        .size   (size_ptr),
        .wr_ptr (wr_ptr_q),
        .rd_ptr (rd_ptr_q),
        .len    (meta_len),
        .alen   (calc_alen),
        .pad    (calc_pad),
        .free   (calc_free),
        .fits   (calc_fits)
    );

`ifdef TCP_RX_SESSION_FILTER_EN
    assign meta_drop = (meta_len == 16'd0) || ({16'd0, meta_len} > size_q) ||
                       (meta_session != session_id_q);
`else
    logic unused_session;
    assign unused_session = ^meta_session;
    assign meta_drop = (meta_len == 16'd0) || ({16'd0, meta_len} > size_q);
`endif

    // A pending cfg takes the IDLE slot, so meta is held off in that cycle.
    assign s_cfg_ready          = (state_q == UNCFG) || (state_q == IDLE);
    assign s_axis_rx_meta_ready = (state_q == IDLE) && !s_cfg_valid &&
                                  (meta_drop || calc_fits);
    assign cfg_hs  = s_cfg_valid && s_cfg_ready;
    assign meta_hs = s_axis_rx_meta_valid && s_axis_rx_meta_ready;

    // wr_ptr already includes the pad once the meta has been accepted.
    assign m_axis_dma_write_cmd_valid   = (state_q == CMD);
    assign m_axis_dma_write_cmd_address = base_q + 64'(wr_ptr_q & (size_ptr - 1'b1));
    assign m_axis_dma_write_cmd_length  = {16'd0, len_p0};

    // Payload passes through with no register stage.
    assign m_axis_dma_write_data_valid = (state_q == STREAM) && s_axis_rx_data_valid;
    assign s_axis_rx_data_ready        = ((state_q == STREAM) && m_axis_dma_write_data_ready) ||
                                         (state_q == DROP);
    assign m_axis_dma_write_data_data  = s_axis_rx_data_data;
    assign m_axis_dma_write_data_keep  = s_axis_rx_data_keep;
    assign m_axis_dma_write_data_last  = s_axis_rx_data_last;

    assign wr_ptr   = wr_ptr_q;
    assign drop_cnt = drop_cnt_q;

    // ---- control state ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= UNCFG;
            base_q     <= '0;
            size_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if ((state_q != UNCFG) && s_rd_ptr_valid)
                rd_ptr_q <= s_rd_ptr;
            if (cfg_hs) begin
                // Later assignment overrides a same-cycle rd_ptr update.
                base_q   <= s_cfg_data[95:32];
                size_q   <= s_cfg_data[31:0];
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                state_q  <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (meta_hs) begin
                            if (meta_drop) begin
                                drop_cnt_q <= sat_inc32(drop_cnt_q);
                                state_q    <= DROP;
                            end else begin
                                wr_ptr_q <= wr_ptr_q + calc_pad;
                                state_q  <= CMD;
                            end
                        end
                    end
                    CMD: begin
                        if (m_axis_dma_write_cmd_ready) begin
                            wr_ptr_q <= wr_ptr_q + alen_p0;
                            state_q  <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (s_axis_rx_data_valid && m_axis_dma_write_data_ready &&
                            s_axis_rx_data_last)
                            state_q <= IDLE;
                    end
                    DROP: begin
                        if (s_axis_rx_data_valid && s_axis_rx_data_last)
                            state_q <= IDLE;
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

`ifdef TCP_RX_SESSION_FILTER_EN
    always_ff @(posedge clk) begin
        if (rst)
            session_id_q <= '0;
        else if (cfg_hs)
            session_id_q <= s_cfg_data[111:96];
    end
`endif

    // ---- per-packet command fields ----
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && meta_hs && !meta_drop) begin
            len_p0  <= meta_len;
            alen_p0 <= calc_alen;
        end
    end

endmodule

// File: tb/tb_tcp_rx_to_dma_write.sv
// tb_tcp_rx_to_dma_write
//   Directed bench for tcp_rx_to_dma_write (DATA_W=64, PTR_W=32).
//   Honors TCP_RX_SESSION_FILTER_EN for the cfg width and the session test.
module tb_tcp_rx_to_dma_write;

    localparam int DATA_W = 64;
    localparam int PTR_W  = 32;
`ifdef TCP_RX_SESSION_FILTER_EN
    localparam int CFG_W = 112;
`else
    localparam int CFG_W = 96;
`endif

    logic                clk;
    logic                rst;
    logic                s_cfg_valid;
    logic                s_cfg_ready;
    logic [CFG_W-1:0]    s_cfg_data;
    logic                s_rd_ptr_valid;
    logic [PTR_W-1:0]    s_rd_ptr;
    logic                meta_valid;
    logic                meta_ready;
    logic [31:0]         meta_data;
    logic                rx_valid;
    logic                rx_ready;
    logic [DATA_W-1:0]   rx_data;
    logic [DATA_W/8-1:0] rx_keep;
    logic                rx_last;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [63:0]         cmd_address;
    logic [31:0]         cmd_length;
    logic                wd_valid;
    logic                wd_ready;
    logic [DATA_W-1:0]   wd_data;
    logic [DATA_W/8-1:0] wd_keep;
    logic                wd_last;
    logic [PTR_W-1:0]    wr_ptr;
    logic [31:0]         drop_cnt;
`ifdef TCP_RX_SESSION_FILTER_EN
    logic [15:0]         cfg_sid;
`endif

    int total;
    int bad;

    tcp_rx_to_dma_write #(
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .s_cfg_valid                  (s_cfg_valid),
        .s_cfg_ready                  (s_cfg_ready),
        .s_cfg_data                   (s_cfg_data),
        .s_rd_ptr_valid               (s_rd_ptr_valid),
        .s_rd_ptr                     (s_rd_ptr),
        .s_axis_rx_meta_valid         (meta_valid),
        .s_axis_rx_meta_ready         (meta_ready),
        .s_axis_rx_meta_data          (meta_data),
        .s_axis_rx_data_valid         (rx_valid),
        .s_axis_rx_data_ready         (rx_ready),
        .s_axis_rx_data_data          (rx_data),
        .s_axis_rx_data_keep          (rx_keep),
        .s_axis_rx_data_last          (rx_last),
        .m_axis_dma_write_cmd_valid   (cmd_valid),
        .m_axis_dma_write_cmd_ready   (cmd_ready),
        .m_axis_dma_write_cmd_address (cmd_address),
        .m_axis_dma_write_cmd_length  (cmd_length),
        .m_axis_dma_write_data_valid  (wd_valid),
        .m_axis_dma_write_data_ready  (wd_ready),
        .m_axis_dma_write_data_data   (wd_data),
        .m_axis_dma_write_data_keep   (wd_keep),
        .m_axis_dma_write_data_last   (wd_last),
        .wr_ptr                       (wr_ptr),
        .drop_cnt                     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [63:0] b, input logic [31:0] sz);
        s_cfg_valid = 1'b1;
`ifdef TCP_RX_SESSION_FILTER_EN
        s_cfg_data  = {cfg_sid, b, sz};
`else
        s_cfg_data  = {b, sz};
`endif
        #1;
        chk("cfg_ready", 64'(s_cfg_ready), 64'd1);
        tick();
        s_cfg_valid = 1'b0;
    endtask

    // One-beat packet end, consumed by the DUT in STREAM or DROP.
    task automatic last_beat(input logic [63:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_keep  = 8'hFF;
        rx_last  = 1'b1;
        wd_ready = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    // Accepts a fitting meta and completes its command handshake.
    task automatic meta_and_cmd(input logic [15:0] len, input logic [15:0] sess);
        meta_valid = 1'b1;
        meta_data  = {len, sess};
        tick();
        meta_valid = 1'b0;
        cmd_ready  = 1'b1;
        tick();
        cmd_ready  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        s_cfg_valid = 1'b0;
        s_cfg_data = '0;
        s_rd_ptr_valid = 1'b0;
        s_rd_ptr = '0;
        meta_valid = 1'b0;
        meta_data = '0;
        rx_valid = 1'b0;
        rx_data = '0;
        rx_keep = '0;
        rx_last = 1'b0;
        cmd_ready = 1'b0;
        wd_ready = 1'b0;
`ifdef TCP_RX_SESSION_FILTER_EN
        cfg_sid = 16'd2;
`endif
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_cfg_ready", 64'(s_cfg_ready), 64'd1);
        chk("rst_meta_ready", 64'(meta_ready), 64'd0);
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_wd_valid", 64'(wd_valid), 64'd0);
        chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // Basic packet: len 100 -> one 128-byte slot at offset 0
        do_cfg(64'h1000_0000, 32'h1000);
        meta_valid = 1'b1;
        meta_data  = {16'd100, 16'd2};
        #1;
        chk("s1_meta_ready", 64'(meta_ready), 64'd1);
        tick();
        meta_valid = 1'b0;
        rx_valid   = 1'b1;
        rx_data    = 64'hA5A5_0001_0000_0001;
        wd_ready   = 1'b1;
        #1;
        chk("s1_cmd_valid", 64'(cmd_valid), 64'd1);
        chk("s1_cmd_addr", cmd_address, 64'h1000_0000);
        chk("s1_cmd_len", 64'(cmd_length), 64'd100);
        chk("s1_rx_ready_cmd", 64'(rx_ready), 64'd0);
        chk("s1_wd_valid_cmd", 64'(wd_valid), 64'd0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        rx_keep   = 8'hFF;
        rx_last   = 1'b0;
        #1;
        chk("s1_wr_ptr", 64'(wr_ptr), 64'd128);
        chk("s1_cmd_done", 64'(cmd_valid), 64'd0);
        chk("s1_b0_valid", 64'(wd_valid), 64'd1);
        chk("s1_b0_data", wd_data, 64'hA5A5_0001_0000_0001);
        chk("s1_b0_ready", 64'(rx_ready), 64'd1);
        chk("s1_b0_last", 64'(wd_last), 64'd0);
        wd_ready = 1'b0;
        #1;
        chk("s1_bp_ready", 64'(rx_ready), 64'd0);
        wd_ready = 1'b1;
        tick();
        rx_data = 64'hA5A5_0002_0000_0002;
        rx_keep = 8'h0F;
        rx_last = 1'b1;
        #1;
        chk("s1_b1_data", wd_data, 64'hA5A5_0002_0000_0002);
        chk("s1_b1_keep", 64'(wd_keep), 64'h0F);
        chk("s1_b1_last", 64'(wd_last), 64'd1);
        tick();
        rx_last = 1'b0;
        #1;
        chk("s1_idle_rx_ready", 64'(rx_ready), 64'd0);
        chk("s1_idle_wd_valid", 64'(wd_valid), 64'd0);
        rx_valid = 1'b0;

        // Wrap: wr_ptr=rd_ptr=0xFC0, len 128 needs 64 bytes of pad
        do_cfg(64'h1000_0000, 32'h1000);
        chk("s2_cfg_wr_ptr", 64'(wr_ptr), 64'd0);
        meta_and_cmd(16'h0FC0, 16'd2);
        chk("s2_fill_wr_ptr", 64'(wr_ptr), 64'h0FC0);
        last_beat(64'h1);
        s_rd_ptr_valid = 1'b1;
        s_rd_ptr = 32'h0FC0;
        tick();
        s_rd_ptr_valid = 1'b0;
        meta_valid = 1'b1;
        meta_data  = {16'd128, 16'd2};
        #1;
        chk("s2_meta_ready", 64'(meta_ready), 64'd1);
        tick();
        meta_valid = 1'b0;
        #1;
        chk("s2_pad_wr_ptr", 64'(wr_ptr), 64'h1000);
        chk("s2_cmd_addr", cmd_address, 64'h1000_0000);
        chk("s2_cmd_len", 64'(cmd_length), 64'd128);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        #1;
        chk("s2_wr_ptr", 64'(wr_ptr), 64'h1080);
        last_beat(64'h2);

        // Drops: len 0, then len 0x2000 > ring size
        meta_valid = 1'b1;
        meta_data  = {16'd0, 16'd2};
        #1;
        chk("s4_meta0_ready", 64'(meta_ready), 64'd1);
        tick();
        meta_valid = 1'b0;
        wd_ready = 1'b0;
        #1;
        chk("s4_drop_cnt1", 64'(drop_cnt), 64'd1);
        chk("s4_drop_rx_ready", 64'(rx_ready), 64'd1);
        chk("s4_drop_cmd", 64'(cmd_valid), 64'd0);
        rx_valid = 1'b1;
        rx_last  = 1'b1;
        #1;
        chk("s4_drop_wd_valid", 64'(wd_valid), 64'd0);
        tick();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        meta_valid = 1'b1;
        meta_data  = {16'h2000, 16'd2};
        #1;
        chk("s4_meta_big_ready", 64'(meta_ready), 64'd1);
        tick();
        meta_valid = 1'b0;
        rx_valid = 1'b1;
        #1;
        chk("s4_drop_cnt2", 64'(drop_cnt), 64'd2);
        chk("s4_drain_ready", 64'(rx_ready), 64'd1);
        chk("s4_drain_wd_valid", 64'(wd_valid), 64'd0);
        tick();
        rx_last = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        #1;
        chk("s4_idle_rx_ready", 64'(rx_ready), 64'd0);
        chk("s4_no_cmd", 64'(cmd_valid), 64'd0);
        chk("s4_wr_ptr", 64'(wr_ptr), 64'h1080);

        // Full ring back-pressure, released by a rd_ptr update
        do_cfg(64'h1000_0000, 32'h1000);
        meta_and_cmd(16'h0FC0, 16'd2);
        last_beat(64'h3);
        meta_valid = 1'b1;
        meta_data  = {16'd128, 16'd2};
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s3_full_ready", 64'(meta_ready), 64'd0);
            chk("s3_full_cmd", 64'(cmd_valid), 64'd0);
            tick();
        end
        s_rd_ptr_valid = 1'b1;
        s_rd_ptr = 32'h100;
        #1;
        chk("s3_pre_rd_ready", 64'(meta_ready), 64'd0);
        tick();
        s_rd_ptr_valid = 1'b0;
        #1;
        chk("s3_rd_ready", 64'(meta_ready), 64'd1);
        tick();
        meta_valid = 1'b0;

        // Command held by cmd_ready=0 for 10 cycles
        rx_valid = 1'b1;
        rx_last  = 1'b0;
        rx_data  = 64'hDEAD_BEEF_0000_0005;
        wd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("s5_cmd_valid", 64'(cmd_valid), 64'd1);
            chk("s5_cmd_addr", cmd_address, 64'h1000_0000);
            chk("s5_cmd_len", 64'(cmd_length), 64'd128);
            chk("s5_rx_ready", 64'(rx_ready), 64'd0);
            tick();
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        #1;
        chk("s5_wr_ptr", 64'(wr_ptr), 64'h1080);
        chk("s5_stream_valid", 64'(wd_valid), 64'd1);
        tick();

        // Reset in the middle of STREAM, upstream reset together
        rst = 1'b1;
        rx_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("s6_cfg_ready", 64'(s_cfg_ready), 64'd1);
        chk("s6_wr_ptr", 64'(wr_ptr), 64'd0);
        chk("s6_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("s6_wd_valid", 64'(wd_valid), 64'd0);
        chk("s6_rx_ready", 64'(rx_ready), 64'd0);
        chk("s6_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("s6_meta_ready", 64'(meta_ready), 64'd0);

`ifdef TCP_RX_SESSION_FILTER_EN
        // Session filter: session_id=1
        cfg_sid = 16'd1;
        do_cfg(64'h1000_0000, 32'h1000);
        meta_valid = 1'b1;
        meta_data  = {16'd100, 16'd2};
        #1;
        chk("f_foreign_ready", 64'(meta_ready), 64'd1);
        tick();
        meta_valid = 1'b0;
        #1;
        chk("f_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("f_drop_cmd", 64'(cmd_valid), 64'd0);
        chk("f_drop_rx_ready", 64'(rx_ready), 64'd1);
        last_beat(64'h4);
        meta_valid = 1'b1;
        meta_data  = {16'd100, 16'd1};
        tick();
        meta_valid = 1'b0;
        #1;
        chk("f_own_cmd", 64'(cmd_valid), 64'd1);
        chk("f_own_addr", cmd_address, 64'h1000_0000);
        chk("f_own_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcp_rx_to_dma_write.md
TCP_RX_TO_DMA_WRITE -- requirements
Module: tcp_rx_to_dma_write

Interface
REQ-001 SHALL have parameter DATA_W, default 512, the data-path width in bits; keep width SHALL be DATA_W/8.
REQ-002 SHALL have parameter PTR_W, default 32, the width of the ring byte pointers.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; it SHALL be synchronous and active-high.
REQ-005 SHALL have ports s_cfg_valid/ready (1/1) and s_cfg_data (input, 96) = {base_addr[95:32], ring_size[31:0]}.
REQ-006 SHALL have ports s_rd_ptr_valid (input, 1) and s_rd_ptr (input, PTR_W), the host-consumed byte pointer.
REQ-007 SHALL have ports s_axis_rx_meta_valid/ready (1/1) and s_axis_rx_meta_data (input, 32) = {len[31:16], session[15:0]}.
REQ-008 SHALL have ports s_axis_rx_data_valid/ready (1/1), _data (input, DATA_W), _keep (input, DATA_W/8) and _last (input, 1).
REQ-009 SHALL have ports m_axis_dma_write_cmd_valid/ready (1/1), _address (output, 64) and _length (output, 32).
REQ-010 SHALL have ports m_axis_dma_write_data_valid/ready (1/1), _data (output, DATA_W), _keep (output, DATA_W/8) and _last (output, 1).
REQ-011 SHALL have ports wr_ptr (output, PTR_W), the produced byte pointer, and drop_cnt (output, 32), the count of dropped packets.

Function
REQ-012 SHALL implement FSM states UNCFG, IDLE, CMD, STREAM, DROP.
- UNCFG: s_cfg_ready=1. On cfg handshake, SHALL latch base and size, clear wr_ptr and rd_ptr, and go to IDLE.
- ring_size SHALL be a power of two and at least 64. Cfg SHALL be accepted only in UNCFG or IDLE; s_cfg_ready SHALL be 1 in those states.
REQ-013 rd_ptr SHALL load from s_rd_ptr on any cycle s_rd_ptr_valid=1, in every state except UNCFG.
REQ-014 Per packet, the block SHALL compute:
- alen = len rounded up to a multiple of 64;
- off = wr_ptr & (size-1);
- pad = (off+alen > size) ? size-off : 0;
- free = size - (wr_ptr - rd_ptr), computed modulo 2^PTR_W.
REQ-015 In IDLE, s_axis_rx_meta_ready SHALL be 1 only if free >= pad+alen for the presented meta, or if that meta is a drop case (REQ-018). Otherwise the block SHALL back-pressure and not drop.
REQ-016 On meta accept, the block SHALL set wr_ptr += pad and go to CMD.
- In CMD, cmd_valid=1 with address = base + ((wr_ptr+pad) & (size-1)) and length = len; cmd fields SHALL be held stable until ready.
- On cmd handshake: wr_ptr += alen, then go to STREAM.
REQ-017 In STREAM, data SHALL pass through combinationally: m_valid = s_valid, s_ready = m_ready, with data/keep/last forwarded. On a last beat handshake the block SHALL return to IDLE. Zero added latency.
REQ-018 A meta with len=0 or len>size SHALL be accepted immediately, increment drop_cnt, and go to DROP. DROP SHALL hold s_axis_rx_data_ready=1 and issue no DMA until a last beat, then return to IDLE.
REQ-019 Pointer arithmetic SHALL wrap modulo 2^PTR_W. drop_cnt SHALL saturate at 2^32-1.
REQ-020 A cfg handshake and an s_rd_ptr update in the same cycle: cfg SHALL win and clear rd_ptr.
REQ-021 rx data SHALL NOT be accepted in UNCFG, IDLE or CMD (s_axis_rx_data_ready=0).

Reset
REQ-022 On rst, the block SHALL:
- enter UNCFG;
- clear wr_ptr, rd_ptr, drop_cnt, base and size;
- drive every valid and ready low except s_cfg_ready=1 on the first post-reset cycle.
REQ-023 Reset mid-packet SHALL abandon the packet with no further DMA beats; the bench SHALL reset upstream together with the block.

Configuration
REQ-024 Macro TCP_RX_SESSION_FILTER_EN:
- When defined, s_cfg_data SHALL be 112 bits, with session_id[111:96] appended. Meta whose session differs from session_id SHALL follow the DROP path (REQ-018).
- When undefined, all sessions SHALL be accepted and cfg SHALL be 96 bits.

Structure
REQ-025 The FSM state enum and the 64-byte alignment constant SHALL live in the shared package tcp_dma_pkg.
REQ-026 Ring space and pad computation SHALL be a sub-module ring_space_calc, which is purely combinational.

Verification
REQ-027 Directed scenarios:
- Cfg base=0x1000_0000, size=0x1000; meta len=100, session 2; 2 beats -> cmd addr 0x1000_0000 len 100; wr_ptr=128; 2 data beats with last on the second.
- wr_ptr=0xFC0, rd_ptr=0xFC0; meta len=128 -> pad 64, cmd addr 0x1000_0000, wr_ptr=0x1080.
- rd_ptr=0, wr_ptr=0xFC0; meta len=128 -> meta_ready stays 0; s_rd_ptr=0x100 -> accepted next cycle.
- meta len=0, then len=0x2000 -> drop_cnt=2, no cmd, data drained.
- cmd_ready held 0 for 10 cycles -> cmd fields stable; data_ready=0 throughout.
- rst asserted mid-STREAM -> UNCFG, all pointers 0, s_cfg_ready=1.
- With TCP_RX_SESSION_FILTER_EN and session_id=1: meta for session 2 -> dropped and drop_cnt=1; meta for session 1 -> DMA issued.
